// File: rtl/memory_responder.sv
// memory_responder: word memory behind an IDLE/WAIT/RESPOND handshake with fixed wait states.
// Defining MEMORY_BYTE_ENABLE_EN adds a byte_enable input for partial-word writes.
module memory_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ReadMemory,
    input  logic        WriteMemory,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
`ifdef MEMORY_BYTE_ENABLE_EN
    input  logic [3:0]  byte_enable,
`endif
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        error
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
    state_t      state;
    logic [3:0]  count;
    logic [31:0] addr_q, data_q;
    logic        rd_q, wr_q;
`ifdef MEMORY_BYTE_ENABLE_EN
    logic [3:0]  be_q;
`endif
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] idx;
    logic        fault, access;
    assign idx    = addr_q[AW+1:2];
    assign fault  = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0) || (rd_q && wr_q);
    assign access = (state == WAIT) && (count == 4'd0);
    assign busy   = state != IDLE;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            ready     <= 1'b0;
            error     <= 1'b0;
            read_data <= 32'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
`ifdef MEMORY_BYTE_ENABLE_EN
            be_q      <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: if (ReadMemory || WriteMemory) begin
                    addr_q <= address;
                    data_q <= write_data;
                    rd_q   <= ReadMemory;
                    wr_q   <= WriteMemory;
`ifdef MEMORY_BYTE_ENABLE_EN
                    be_q   <= byte_enable;
`endif
                    count  <= 4'(WAIT_CYCLES);
                    state  <= WAIT;
                end
                WAIT: if (count != 4'd0) count <= count - 4'd1;
                else begin
                    state <= RESPOND;
                    ready <= 1'b1;
                    error <= fault;
                    if (fault) read_data <= 32'd0;
                    else if (rd_q) read_data <= mem[idx];
                end
                RESPOND: begin
                    ready <= 1'b0;
                    error <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // storage has no reset; access is low whenever reset holds the FSM in IDLE
    always_ff @(posedge clock) begin
        if (access && wr_q && !fault) begin
`ifdef MEMORY_BYTE_ENABLE_EN
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[idx][8*i +: 8] <= data_q[8*i +: 8];
`else
            mem[idx] <= data_q;
`endif
        end
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed checks of latency, faults, ignored strobes and reset abort.
module tb_memory_responder;
    logic        clock = 1'b0, reset = 1'b0, ReadMemory = 1'b0, WriteMemory = 1'b0;
    logic [31:0] address = 32'd0, write_data = 32'd0;
    logic [3:0]  byte_enable = 4'hF;
    logic [31:0] read_data, read_data0;
    logic        ready, busy, error, ready0, busy0, error0;
    logic [31:0] rd;
    logic        er;
    int total = 0, bad = 0;

    always #5 clock = ~clock;

    memory_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .ReadMemory(ReadMemory), .WriteMemory(WriteMemory),
        .address(address), .write_data(write_data),
`ifdef MEMORY_BYTE_ENABLE_EN
        .byte_enable(byte_enable),
`endif
        .read_data(read_data), .ready(ready), .busy(busy), .error(error));

    // minimal configuration: four words, no wait states
    memory_responder #(.DEPTH(4), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .ReadMemory(ReadMemory), .WriteMemory(WriteMemory),
        .address(address), .write_data(write_data),
`ifdef MEMORY_BYTE_ENABLE_EN
        .byte_enable(byte_enable),
`endif
        .read_data(read_data0), .ready(ready0), .busy(busy0), .error(error0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic poke, output logic [31:0] rdo, output logic ero);
        @(negedge clock);
        ReadMemory = r; WriteMemory = w; address = a; write_data = d;
        @(posedge clock); #1;
        ReadMemory = poke; WriteMemory = 1'b0; address = $urandom; write_data = $urandom;
        chk("busy_accept", 32'(busy), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock); #1;
            chk("ready_latency", 32'(ready), 32'(k == 3));
        end
        rdo = read_data; ero = error;
        @(posedge clock); #1;
        chk("ready_one_cycle", 32'(ready), 32'd0);
        ReadMemory = 1'b0;
        @(posedge clock); #1;
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic acc0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdo, output logic ero);
        @(negedge clock);
        ReadMemory = r; WriteMemory = w; address = a; write_data = d;
        @(posedge clock); #1;
        ReadMemory = 1'b0; WriteMemory = 1'b0;
        chk("w0_busy", 32'(busy0), 32'd1);
        chk("w0_not_ready", 32'(ready0), 32'd0);
        @(posedge clock); #1;
        chk("w0_ready", 32'(ready0), 32'd1);
        rdo = read_data0; ero = error0;
        @(posedge clock); #1;
        chk("w0_ready_drop", 32'(ready0), 32'd0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;

        acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er);
        chk("wr10_err", 32'(er), 32'd0);
        acc(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        chk("rd10_data", rd, 32'hDEADBEEF);
        chk("rd10_err", 32'(er), 32'd0);

        acc(1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, rd, er);
        acc(1'b1, 1'b0, 32'h11, 32'h0, 1'b0, rd, er);
        chk("misalign_err", 32'(er), 32'd1);
        chk("misalign_rdata", rd, 32'd0);
        acc(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        acc(1'b0, 1'b1, 32'h400, 32'h99999999, 1'b0, rd, er);
        chk("range_err", 32'(er), 32'd1);
        chk("range_rdata", rd, 32'd0);
        acc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rd, er);
        chk("rd0_data", rd, 32'h11111111);
        chk("rd0_err", 32'(er), 32'd0);

        acc(1'b0, 1'b1, 32'h20, 32'h00002020, 1'b0, rd, er);
        acc(1'b1, 1'b1, 32'h20, 32'h00000BAD, 1'b0, rd, er);
        chk("both_err", 32'(er), 32'd1);
        acc(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
        chk("both_unchanged", rd, 32'h00002020);

        acc(1'b0, 1'b1, 32'h34, 32'h0000CAFE, 1'b1, rd, er);
        chk("poke_err", 32'(er), 32'd0);
        acc(1'b1, 1'b0, 32'h34, 32'h0, 1'b0, rd, er);
        chk("latched_data", rd, 32'h0000CAFE);

        acc(1'b0, 1'b1, 32'h8, 32'h87654321, 1'b0, rd, er);
        @(negedge clock);
        WriteMemory = 1'b1; address = 32'h8; write_data = 32'h12345678;
        @(posedge clock); #1;
        WriteMemory = 1'b0;
        @(posedge clock); #1;
        chk("mid_wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_error", 32'(error), 32'd0);
        chk("abort_rdata", read_data, 32'd0);
        @(posedge clock);
        @(negedge clock) reset = 1'b0;
        acc(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, rd, er);
        chk("abort_kept_old", rd, 32'h87654321);

        acc0(1'b0, 1'b1, 32'hC, 32'h000000A5, rd, er);
        chk("w0_wr_err", 32'(er), 32'd0);
        acc0(1'b1, 1'b0, 32'hC, 32'h0, rd, er);
        chk("w0_rd_data", rd, 32'h000000A5);
        acc0(1'b1, 1'b0, 32'h10, 32'h0, rd, er);
        chk("w0_range_err", 32'(er), 32'd1);
        chk("w0_range_rdata", rd, 32'd0);

`ifdef MEMORY_BYTE_ENABLE_EN
        acc(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 1'b0, rd, er);
        byte_enable = 4'b0001;
        acc(1'b0, 1'b1, 32'h40, 32'h000000AA, 1'b0, rd, er);
        byte_enable = 4'b0000;
        acc(1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0, rd, er);
        chk("be_none_err", 32'(er), 32'd0);
        byte_enable = 4'hF;
        acc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rd, er);
        chk("be_merge", rd, 32'hFFFFFFAA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
